regfile_wb_arbiter: RTL

Owns the single register-file write port (we3/a3/wd3) and shares it between two writeback sources:
- the in-order pipeline WB stage, which has priority;
- the multi-cycle mul/div unit, which uses a valid/ready handshake.
It keeps a busy-bit scoreboard of destination registers with outstanding multi-cycle results, raises a read-hazard stall, and breaks mul/div starvation by stalling pipeline WB. It sits between WB/mul-div and register_block.

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 62 ++++++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback arbiter slice.
package regfile_wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  // Which source the currently registered write came from.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_MD   = 2'd2
  } src_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for destinations with outstanding mul/div results,
// issue admission and decode read-hazard detection.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_a3,
  output logic                  issue_ready,
  input  logic                  cpl_valid,
  input  logic [REG_ADDR_W-1:0] cpl_a3,
  input  logic [REG_ADDR_W-1:0] rs_a1,
  input  logic [REG_ADDR_W-1:0] rs_a2,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_a3,
  input  logic                  wb_from_md,
  output logic                  hazard_stall
);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [PW-1:0]       pending;
  logic [PW-1:0]       pending_next;
  logic                set_busy;
  logic                cpl_hit;
  logic                wb_match;

  assign issue_ready = issue_valid & ~busy[issue_a3] & (pending < PW'(MAX_PENDING));

  // A completion to a non-busy register is a protocol error: it is ignored here.
  always_comb begin
    set_busy     = issue_ready & (issue_a3 != '0);
    cpl_hit      = cpl_valid & busy[cpl_a3];
    busy_next    = busy;
    pending_next = pending;
    if (cpl_hit) busy_next[cpl_a3] = 1'b0;
    // Set after clear so a same-register issue takes ownership.
    if (set_busy) busy_next[issue_a3] = 1'b1;
    if (set_busy && !cpl_hit) pending_next = pending + PW'(1);
    else if (!set_busy && cpl_hit) pending_next = pending - PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      busy    <= busy_next;
      pending <= pending_next;
    end
  end

  // Pipeline-sourced writes in flight are covered by pipeline forwarding.
  always_comb begin
    wb_match     = wb_we & wb_from_md & (wb_a3 != '0) & ((wb_a3 == rs_a1) | (wb_a3 == rs_a2));
    hazard_stall = busy[rs_a1] | busy[rs_a2] | wb_match;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port and arbitrates it between pipeline WB
// (priority) and the mul/div unit, with starvation relief via pipe_stall.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_PENDING  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_a3,
  input  logic [XLEN-1:0]       pipe_wd,
  output logic                  pipe_stall,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_a3,
  input  logic [XLEN-1:0]       md_wd,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_a3,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs_a1,
  input  logic [REG_ADDR_W-1:0] rs_a2,
  output logic                  hazard_stall,
  output logic                  rf_we3,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]       rf_wd3
);
  localparam int SW = 4;

  // Handshake: a mul/div result transfers on any cycle with md_valid & md_ready;
  // md_ready is combinational and md_a3/md_wd must be stable while md_valid is high.
  logic          pipe_grant;
  logic          md_grant;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;
  src_e          src_q;

  always_comb begin
    pipe_grant  = pipe_we & ~pipe_stall;
    md_grant    = md_valid & (pipe_stall | ~pipe_we);
    starve_next = '0;
    if (md_valid && !md_grant)
      starve_next = (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + SW'(1);
  end

  assign md_ready = md_grant;

  // A stall cycle always grants mul/div when it is valid, so the stall lasts
  // one cycle; without md_valid there is nothing left to make room for.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      pipe_stall <= ~pipe_stall & (starve_next == SW'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we3 <= 1'b0;
      rf_a3  <= '0;
      rf_wd3 <= '0;
      src_q  <= SRC_NONE;
    end else if (pipe_grant) begin
      rf_we3 <= (pipe_a3 != '0);
      rf_a3  <= pipe_a3;
      rf_wd3 <= pipe_wd;
      src_q  <= SRC_PIPE;
    end else if (md_grant) begin
      rf_we3 <= (md_a3 != '0);
      rf_a3  <= md_a3;
      rf_wd3 <= md_wd;
      src_q  <= SRC_MD;
    end else begin
      rf_we3 <= 1'b0;
      src_q  <= SRC_NONE;
    end
  end

  regfile_scoreboard #(
    .MAX_PENDING(MAX_PENDING)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (reset),
    .issue_valid  (issue_valid),
    .issue_a3     (issue_a3),
    .issue_ready  (issue_ready),
    .cpl_valid    (md_grant),
    .cpl_a3       (md_a3),
    .rs_a1        (rs_a1),
    .rs_a2        (rs_a2),
    .wb_we        (rf_we3),
    .wb_a3        (rf_a3),
    .wb_from_md   (src_q == SRC_MD),
    .hazard_stall (hazard_stall)
  );
endmodule
